// File: rtl/rr_arbiter_dataless.sv
// Round-robin arbiter sharing one dataless handshake output between SIZE requesters.
// Define RR_ARBITER_OUTPUT_REG_EN to put a one-slot register on outs_valid/index.
module rr_arbiter_dataless #(
  parameter int unsigned SIZE        = 2,
  parameter int unsigned INDEX_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SIZE-1:0]        ins_valid,
  output logic [SIZE-1:0]        ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index
);

  typedef logic [INDEX_WIDTH-1:0] idx_t;

  idx_t            ptr_q, ptr_d;
  idx_t            winner;
  logic            any_valid;
  logic [SIZE-1:0] hi_mask;
  logic [SIZE-1:0] hi_req;

  function automatic idx_t lowest_set(input logic [SIZE-1:0] vec);
    idx_t res;
    res = '0;
    for (int i = int'(SIZE) - 1; i >= 0; i--) begin
      if (vec[i]) res = idx_t'(i);
    end
    return res;
  endfunction

  function automatic idx_t next_ptr(input idx_t cur);
    return (cur == idx_t'(SIZE - 1)) ? '0 : cur + 1'b1;
  endfunction

  function automatic logic [SIZE-1:0] one_hot(input idx_t sel);
    return SIZE'(1) << sel;
  endfunction

  // Requesters at or above ptr win first; otherwise the scan wraps to the lowest one.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      hi_mask[i] = (idx_t'(i) >= ptr_q);
    end
  end

  assign hi_req    = ins_valid & hi_mask;
  assign any_valid = |ins_valid;
  assign winner    = (|hi_req) ? lowest_set(hi_req) : lowest_set(ins_valid);

`ifdef RR_ARBITER_OUTPUT_REG_EN

  logic slot_valid_q, slot_valid_d;
  idx_t slot_idx_q, slot_idx_d;
  logic load_en;

  assign load_en = ~slot_valid_q | outs_ready;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_idx_d   = slot_idx_q;
    ptr_d        = ptr_q;
    ins_ready    = '0;
    if (load_en) begin
      slot_valid_d = any_valid;
      if (any_valid) begin
        slot_idx_d = winner;
        ins_ready  = one_hot(winner);
        ptr_d      = next_ptr(winner);
      end
    end
    if (rst) ins_ready = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_idx_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_idx_q   <= slot_idx_d;
    end
  end

  assign outs_valid = slot_valid_q;
  assign index      = slot_idx_q;

`else

  typedef enum logic {StIdle, StLocked} state_e;

  state_e state_q, state_d;
  idx_t   grant_q, grant_d;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    outs_valid = 1'b0;
    index      = grant_q;
    ins_ready  = '0;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          outs_valid = 1'b1;
          index      = winner;
          if (outs_ready) begin
            ins_ready = one_hot(winner);
            ptr_d     = next_ptr(winner);
          end else begin
            // Offer is now visible downstream; freeze it until accepted.
            grant_d = winner;
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        outs_valid = 1'b1;
        if (outs_ready) begin
          ins_ready = one_hot(grant_q);
          ptr_d     = next_ptr(grant_q);
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are combinational, so reset has to mask them directly.
    if (rst) begin
      outs_valid = 1'b0;
      ins_ready  = '0;
      index      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: tb/tb_rr_arbiter_dataless.sv
// Directed bench for rr_arbiter_dataless (combinational-output build), SIZE=4 and SIZE=3.
module tb_rr_arbiter_dataless;

  logic       clk;
  logic       rst;
  logic [3:0] iv4, ir4;
  logic       ov4, or4;
  logic [1:0] idx4;
  logic [2:0] iv3, ir3;
  logic       ov3, or3;
  logic [1:0] idx3;

  int checks = 0;
  int errors = 0;

  rr_arbiter_dataless #(.SIZE(4), .INDEX_WIDTH(2)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (iv4),
    .ins_ready  (ir4),
    .outs_valid (ov4),
    .outs_ready (or4),
    .index      (idx4)
  );

  rr_arbiter_dataless #(.SIZE(3), .INDEX_WIDTH(2)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (iv3),
    .ins_ready  (ir3),
    .outs_valid (ov3),
    .outs_ready (or3),
    .index      (idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An offer left pending at an edge must keep its requester valid afterwards.
  logic       held_q;
  logic [1:0] held_idx_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q     <= 1'b0;
      held_idx_q <= 2'd0;
    end else begin
      held_q     <= ov4 & ~or4;
      held_idx_q <= idx4;
    end
  end

  always @(negedge clk) begin
    if (!rst && held_q) begin
      checks++;
      assert (iv4[held_idx_q] === 1'b1) else begin
        errors++;
        $error("FAIL protocol_hold observed=%0b expected=1", iv4[held_idx_q]);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iv4 = 4'b0000;
    or4 = 1'b0;
    iv3 = 3'b000;
    or3 = 1'b0;
    #2;
    check("rst_ov", {31'd0, ov4}, 32'd0);
    check("rst_ir", {28'd0, ir4}, 32'd0);
    check("rst_idx", {30'd0, idx4}, 32'd0);
    iv4 = 4'b1111;
    or4 = 1'b1;
    #1;
    check("rst_mask_ov", {31'd0, ov4}, 32'd0);
    check("rst_mask_ir", {28'd0, ir4}, 32'd0);
    iv4 = 4'b0000;
    or4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Single requester, zero latency; ptr moves to 3.
    iv4 = 4'b0100;
    or4 = 1'b1;
    #1;
    check("single_ov", {31'd0, ov4}, 32'd1);
    check("single_idx", {30'd0, idx4}, 32'd2);
    check("single_ir", {28'd0, ir4}, 32'b0100);
    tick();
    iv4 = 4'b1111;
    #1;
    check("ptr3_idx", {30'd0, idx4}, 32'd3);
    check("ptr3_ir", {28'd0, ir4}, 32'b1000);
    tick();

    // Fair rotation from ptr=0.
    for (int i = 0; i < 8; i++) begin
      check("rot_ov", {31'd0, ov4}, 32'd1);
      check("rot_idx", {30'd0, idx4}, i % 4);
      check("rot_ir", {28'd0, ir4}, 32'd1 << (i % 4));
      tick();
    end

    // Lock under backpressure, then a higher-priority arrival must not steal it.
    iv4 = 4'b0010;
    or4 = 1'b0;
    #1;
    check("lock_ov", {31'd0, ov4}, 32'd1);
    check("lock_idx0", {30'd0, idx4}, 32'd1);
    check("lock_ir0", {28'd0, ir4}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lock_idx", {30'd0, idx4}, 32'd1);
      check("lock_ir", {28'd0, ir4}, 32'd0);
    end
    iv4 = 4'b0011;
    #1;
    check("lock_newreq_idx", {30'd0, idx4}, 32'd1);
    check("lock_newreq_ir", {28'd0, ir4}, 32'd0);
    check("lock_newreq_ov", {31'd0, ov4}, 32'd1);
    or4 = 1'b1;
    #1;
    check("lock_accept_ir", {28'd0, ir4}, 32'b0010);
    check("lock_accept_idx", {30'd0, idx4}, 32'd1);
    tick();
    // ptr=2: scan 2,3,0 picks 0.
    iv4 = 4'b0001;
    #1;
    check("after_lock_idx", {30'd0, idx4}, 32'd0);
    check("after_lock_ir", {28'd0, ir4}, 32'b0001);
    tick();
    iv4 = 4'b0000;
    #1;
    check("idle_ov", {31'd0, ov4}, 32'd0);
    check("idle_idx_grant", {30'd0, idx4}, 32'd1);
    check("idle_ir", {28'd0, ir4}, 32'd0);

    // Reset asserted between edges while locked on requester 3.
    iv4 = 4'b1000;
    or4 = 1'b0;
    tick();
    check("lock3_idx", {30'd0, idx4}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_ov", {31'd0, ov4}, 32'd0);
    check("midrst_ir", {28'd0, ir4}, 32'd0);
    check("midrst_idx", {30'd0, idx4}, 32'd0);
    or4 = 1'b1;
    #1;
    check("midrst_ir_rdy", {28'd0, ir4}, 32'd0);
    or4 = 1'b0;
    iv4 = 4'b1001;
    tick();
    rst = 1'b0;
    #1;
    check("postrst_ov", {31'd0, ov4}, 32'd1);
    check("postrst_idx", {30'd0, idx4}, 32'd0);
    check("postrst_ir", {28'd0, ir4}, 32'd0);
    or4 = 1'b1;
    #1;
    check("postrst_accept_ir", {28'd0, ir4}, 32'b0001);
    tick();
    iv4 = 4'b1000;
    #1;
    check("postrst_next_idx", {30'd0, idx4}, 32'd3);
    tick();
    iv4 = 4'b0000;
    or4 = 1'b0;

    // Wrap-around with SIZE=3.
    iv3 = 3'b010;
    or3 = 1'b1;
    #1;
    check("w3_first_idx", {30'd0, idx3}, 32'd1);
    check("w3_first_ir", {29'd0, ir3}, 32'b010);
    tick();
    iv3 = 3'b101;
    #1;
    check("w3_ptr2_idx", {30'd0, idx3}, 32'd2);
    check("w3_ptr2_ir", {29'd0, ir3}, 32'b100);
    check("w3_ptr2_ov", {31'd0, ov3}, 32'd1);
    tick();
    iv3 = 3'b001;
    #1;
    check("w3_wrap_idx", {30'd0, idx3}, 32'd0);
    check("w3_wrap_ir", {29'd0, ir3}, 32'b001);
    tick();
    iv3 = 3'b011;
    #1;
    check("w3_ptr1_idx", {30'd0, idx3}, 32'd1);
    tick();
    iv3 = 3'b000;
    or3 = 1'b0;
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
